// File: rtl/nv_assert_err_arb_if.sv
// Report channel from the checker error arbiter to its consumer (logger or CSR block).
interface nv_assert_err_arb_if #(
    parameter int IDX_W = 3,
    parameter int OCC_W = 8
);
    logic             rpt_valid;
    logic             rpt_ready;
    logic [IDX_W-1:0] rpt_idx;
    logic [OCC_W-1:0] rpt_occ;

    modport master (output rpt_valid, output rpt_idx, output rpt_occ, input rpt_ready);
    modport slave  (input rpt_valid, input rpt_idx, input rpt_occ, output rpt_ready);
endinterface

// File: rtl/nv_assert_err_arb.sv
// Round-robin arbiter turning checker violation pulses into one report record at a time; fire -> rpt_valid in 2 cycles.
// rpt_ready low holds the record stable while events keep accumulating per source; a report limit can mute it.
module nv_assert_err_arb #(
    parameter int NUM_SRC    = 8,
    parameter int IDX_W      = 3,
    parameter int OCC_W      = 8,
    parameter int CNT_W      = 16,
    parameter int MAX_REPORT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_event,
    input  logic                assert_off,
    input  logic [NUM_SRC-1:0]  fire,
    nv_assert_err_arb_if.master rpt,
    output logic [CNT_W-1:0]    total_cnt,
    output logic                suppressed
);

    localparam int                RCNT_W    = (MAX_REPORT > 0) ? $clog2(MAX_REPORT + 1) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'((MAX_REPORT > 0) ? MAX_REPORT - 1 : 0);
    localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NUM_SRC - 1);
    localparam logic [OCC_W-1:0]  OCC_MAX   = '1;

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [OCC_W-1:0]   occ_q [NUM_SRC];
    logic [OCC_W-1:0]   occ_d [NUM_SRC];
    logic [CNT_W-1:0]   total_q, total_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [OCC_W-1:0]   rocc_q, rocc_d;
    logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
    logic               supp_q, supp_d;

    logic [NUM_SRC-1:0] qual;
    logic               hs;
    logic               hit_limit;
    logic               load;
    logic               gnt_vld;
    logic [IDX_W-1:0]   gnt_idx;
    logic [CNT_W:0]     total_sum;

    // Scan downward so the request closest after 'last' is the final (winning) assignment.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [IDX_W-1:0]   last);
        logic [IDX_W:0] res;
        int             c;
        res = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            c = (int'(last) + k) % NUM_SRC;
            if (req[c]) res = {1'b1, IDX_W'(c)};
        end
        return res;
    endfunction

    assign qual = fire & {NUM_SRC{start_event & ~assert_off}};

    always_comb begin
        hs        = (state_q == ST_FULL) && rpt.rpt_ready;
        // The handshake that reaches the limit must not be followed by a load on the same edge.
        hit_limit = (MAX_REPORT != 0) && hs && (rcnt_q == RCNT_LAST);
        {gnt_vld, gnt_idx} = rr_pick(pend_q, last_q);
        load      = ((state_q == ST_EMPTY) || hs) && gnt_vld && !supp_q && !hit_limit;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (load)    state_d = ST_FULL;
        else if (hs) state_d = ST_EMPTY;
    end

    always_comb begin
        rpt.rpt_valid = (state_q == ST_FULL);
        rpt.rpt_idx   = idx_q;
        rpt.rpt_occ   = rocc_q;
        total_cnt     = total_q;
        suppressed    = supp_q;
    end

    always_comb begin
        pend_d = pend_q;
        occ_d  = occ_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            // A fire colliding with its own grant restarts the count at 1 instead of being lost.
            if (load && (gnt_idx == IDX_W'(i))) begin
                pend_d[i] = qual[i];
                occ_d[i]  = OCC_W'(qual[i]);
            end else if (qual[i]) begin
                pend_d[i] = 1'b1;
                if (occ_q[i] != OCC_MAX) occ_d[i] = occ_q[i] + 1'b1;
            end
        end

        idx_d  = load ? gnt_idx : idx_q;
        rocc_d = load ? occ_q[gnt_idx] : rocc_q;
        last_d = load ? gnt_idx : last_q;

        total_sum = {1'b0, total_q} + (CNT_W + 1)'($countones(qual));
        total_d   = total_sum[CNT_W] ? '1 : total_sum[CNT_W-1:0];

        rcnt_d = rcnt_q;
        if (hs && !supp_q) rcnt_d = rcnt_q + 1'b1;
        supp_d = supp_q | hit_limit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= '0;
            for (int i = 0; i < NUM_SRC; i++) occ_q[i] <= '0;
            total_q <= '0;
            idx_q   <= '0;
            rocc_q  <= '0;
            last_q  <= LAST_RST;
            rcnt_q  <= '0;
            supp_q  <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            occ_q   <= occ_d;
            total_q <= total_d;
            idx_q   <= idx_d;
            rocc_q  <= rocc_d;
            last_q  <= last_d;
            rcnt_q  <= rcnt_d;
            supp_q  <= supp_d;
        end
    end

endmodule

// File: tb/tb_nv_assert_err_arb.sv
// Directed scenarios plus randomized traffic checked against a spec-level reference model.
module tb_nv_assert_err_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_event;
    logic        assert_off;
    logic [7:0]  fire;
    logic [15:0] total_cnt, lim_total;
    logic        suppressed, lim_supp;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nv_assert_err_arb_if #(.IDX_W(3), .OCC_W(8)) rpt_if ();
    nv_assert_err_arb_if #(.IDX_W(3), .OCC_W(8)) lim_if ();

    nv_assert_err_arb #(.NUM_SRC(8), .IDX_W(3), .OCC_W(8), .CNT_W(16), .MAX_REPORT(16)) dut (
        .clk(clk), .reset(reset), .start_event(start_event), .assert_off(assert_off),
        .fire(fire), .rpt(rpt_if), .total_cnt(total_cnt), .suppressed(suppressed));

    nv_assert_err_arb #(.NUM_SRC(8), .IDX_W(3), .OCC_W(8), .CNT_W(16), .MAX_REPORT(4)) dut_lim (
        .clk(clk), .reset(reset), .start_event(start_event), .assert_off(assert_off),
        .fire(fire), .rpt(lim_if), .total_cnt(lim_total), .suppressed(lim_supp));

    // Reference model of the MAX_REPORT=16 instance: clear on grant, then add this cycle's events.
    localparam int M_MAX = 16;
    int m_pend [8];
    int m_occ  [8];
    int m_total, m_last, m_rcnt, m_idx, m_rocc;
    bit m_full, m_supp;

    always @(posedge clk) begin : model
        bit hs, hit;
        int g, pop;
        if (reset) begin
            for (int i = 0; i < 8; i++) begin m_pend[i] = 0; m_occ[i] = 0; end
            m_total = 0; m_last = 7; m_rcnt = 0; m_idx = 0; m_rocc = 0;
            m_full = 0; m_supp = 0;
        end else begin
            hs  = m_full && (rpt_if.rpt_ready === 1'b1);
            hit = hs && (m_rcnt + 1 == M_MAX);
            if (hs) m_rcnt++;
            g = -1;
            for (int k = 1; k <= 8; k++)
                if (g < 0 && m_pend[(m_last + k) % 8] != 0) g = (m_last + k) % 8;
            if ((!m_full || hs) && g >= 0 && !m_supp && !hit) begin
                m_idx = g; m_rocc = m_occ[g]; m_pend[g] = 0; m_occ[g] = 0;
                m_full = 1; m_last = g;
            end else if (hs) begin
                m_full = 0;
            end
            pop = 0;
            for (int i = 0; i < 8; i++) begin
                if (fire[i] && start_event && !assert_off) begin
                    m_pend[i] = 1;
                    if (m_occ[i] < 255) m_occ[i]++;
                    pop++;
                end
            end
            m_total = (m_total + pop > 65535) ? 65535 : m_total + pop;
            if (hit) m_supp = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; fire = '0; start_event = 1'b1; assert_off = 1'b0;
        rpt_if.rpt_ready = 1'b0; lim_if.rpt_ready = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ, total_cnt, suppressed} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_main: got v=%0b idx=%0d occ=%0d tot=%0d sup=%0b expected all 0",
                     rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ, total_cnt, suppressed);
        end
        n_cmp++;
        if ({lim_if.rpt_valid, lim_if.rpt_idx, lim_if.rpt_occ, lim_total, lim_supp} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_lim: got v=%0b idx=%0d occ=%0d tot=%0d sup=%0b expected all 0",
                     lim_if.rpt_valid, lim_if.rpt_idx, lim_if.rpt_occ, lim_total, lim_supp);
        end
    endtask

    task automatic test_single();
        do_reset();
        rpt_if.rpt_ready = 1'b1;
        fire = 8'h08; step();
        fire = 8'h00;
        n_cmp++;
        if (rpt_if.rpt_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_early: got v=%0b expected 0", rpt_if.rpt_valid);
        end
        step();
        n_cmp++;
        if ({rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ, total_cnt} !== {1'b1, 3'd3, 8'd1, 16'd1}) begin
            n_fail++;
            $display("FAIL single_rec: got v=%0b idx=%0d occ=%0d tot=%0d expected v=1 idx=3 occ=1 tot=1",
                     rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ, total_cnt);
        end
        step();
        n_cmp++;
        if (rpt_if.rpt_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_drain: got v=%0b expected 0", rpt_if.rpt_valid);
        end
    endtask

    task automatic test_masking();
        do_reset();
        rpt_if.rpt_ready = 1'b1;
        assert_off = 1'b1; fire = 8'h02; step();
        assert_off = 1'b0; start_event = 1'b0; step();
        fire = 8'h00; start_event = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_cmp++;
            if ({rpt_if.rpt_valid, total_cnt} !== 17'd0) begin
                n_fail++;
                $display("FAIL masking cyc%0d: got v=%0b tot=%0d expected v=0 tot=0",
                         c, rpt_if.rpt_valid, total_cnt);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        fire = 8'hFF; step();
        fire = 8'h00; step();
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if ({rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ} !== {1'b1, 3'd0, 8'd1}) begin
                n_fail++;
                $display("FAIL rr_hold cyc%0d: got v=%0b idx=%0d occ=%0d expected v=1 idx=0 occ=1",
                         c, rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ);
            end
            if (c < 4) step();
        end
        rpt_if.rpt_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            step();
            n_cmp++;
            if ({rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ} !== {1'b1, 3'(k), 8'd1}) begin
                n_fail++;
                $display("FAIL rr_seq k=%0d: got v=%0b idx=%0d occ=%0d expected v=1 idx=%0d occ=1",
                         k, rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ, k);
            end
        end
        step();
        n_cmp++;
        if ({rpt_if.rpt_valid, total_cnt} !== {1'b0, 16'd8}) begin
            n_fail++;
            $display("FAIL rr_end: got v=%0b tot=%0d expected v=0 tot=8", rpt_if.rpt_valid, total_cnt);
        end
    endtask

    task automatic test_accumulate();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            fire = 8'h04;
            rpt_if.rpt_ready = (k >= 298);
            step();
            if (k == 1 || k == 150) begin
                n_cmp++;
                if ({rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ} !== {1'b1, 3'd2, 8'd1}) begin
                    n_fail++;
                    $display("FAIL accum_first k=%0d: got v=%0b idx=%0d occ=%0d expected v=1 idx=2 occ=1",
                             k, rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ);
                end
            end
            if (k == 298) begin
                n_cmp++;
                if ({rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ} !== {1'b1, 3'd2, 8'd255}) begin
                    n_fail++;
                    $display("FAIL accum_sat: got v=%0b idx=%0d occ=%0d expected v=1 idx=2 occ=255",
                             rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ);
                end
            end
        end
        fire = 8'h00;
        n_cmp++;
        if (total_cnt !== 16'd300) begin
            n_fail++; $display("FAIL accum_total: got %0d expected 300", total_cnt);
        end
        step(); step(); step();
    endtask

    task automatic test_limit();
        int hs_cnt;
        do_reset();
        lim_if.rpt_ready = 1'b1;
        hs_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            fire = (k < 20 && (k % 2) == 0) ? 8'h01 : 8'h00;
            step();
            if (lim_if.rpt_valid === 1'b1) hs_cnt++;
        end
        n_cmp++;
        if (hs_cnt !== 4) begin
            n_fail++; $display("FAIL limit_hs: got %0d handshakes expected 4", hs_cnt);
        end
        n_cmp++;
        if ({lim_supp, lim_total} !== {1'b1, 16'd10}) begin
            n_fail++; $display("FAIL limit_state: got sup=%0b tot=%0d expected sup=1 tot=10", lim_supp, lim_total);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fire = 8'h40; step();
        fire = 8'h00; step();
        n_cmp++;
        if ({rpt_if.rpt_valid, rpt_if.rpt_idx} !== {1'b1, 3'd6}) begin
            n_fail++; $display("FAIL rmid_pre: got v=%0b idx=%0d expected v=1 idx=6", rpt_if.rpt_valid, rpt_if.rpt_idx);
        end
        reset = 1'b1; fire = 8'hFF; rpt_if.rpt_ready = 1'b1; step();
        reset = 1'b0; fire = 8'h00;
        n_cmp++;
        if ({rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ, total_cnt, suppressed} !== 29'd0) begin
            n_fail++;
            $display("FAIL rmid_clear: got v=%0b idx=%0d occ=%0d tot=%0d sup=%0b expected all 0",
                     rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ, total_cnt, suppressed);
        end
        step();
        n_cmp++;
        if (rpt_if.rpt_valid !== 1'b0) begin
            n_fail++; $display("FAIL rmid_idle: got v=%0b expected 0", rpt_if.rpt_valid);
        end
        fire = 8'h20; step();
        fire = 8'h00; step();
        n_cmp++;
        if ({rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ} !== {1'b1, 3'd5, 8'd1}) begin
            n_fail++;
            $display("FAIL rmid_new: got v=%0b idx=%0d occ=%0d expected v=1 idx=5 occ=1",
                     rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ);
        end
    endtask

    task automatic test_random();
        do_reset();
        lim_if.rpt_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < 8; i++) fire[i] = ($urandom_range(0, 3) == 0);
            start_event = ($urandom_range(0, 9) != 0);
            assert_off  = ($urandom_range(0, 9) == 0);
            rpt_if.rpt_ready = ($urandom_range(0, 9) < 7);
            step();
            n_cmp++;
            if (rpt_if.rpt_valid !== m_full || total_cnt !== 16'(m_total) || suppressed !== m_supp ||
                (m_full && (rpt_if.rpt_idx !== 3'(m_idx) || rpt_if.rpt_occ !== 8'(m_rocc)))) begin
                n_fail++;
                $display("FAIL random cyc%0d: got v=%0b idx=%0d occ=%0d tot=%0d sup=%0b expected v=%0b idx=%0d occ=%0d tot=%0d sup=%0b",
                         c, rpt_if.rpt_valid, rpt_if.rpt_idx, rpt_if.rpt_occ, total_cnt, suppressed,
                         m_full, m_idx, m_rocc, m_total, m_supp);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fire = '0; start_event = 1'b0; assert_off = 1'b0;
        rpt_if.rpt_ready = 1'b0; lim_if.rpt_ready = 1'b0;
        test_reset();
        test_single();
        test_masking();
        test_round_robin();
        test_accumulate();
        test_limit();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
